// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - byte-memory read bus between the fetch unit and the memory/LSU port
// Signals:
//   mem_addr  byte address of the current fetch (master drives)
//   mem_re    read request, held until accepted (master drives)
//   mem_rdy   mem_data valid this cycle; read accepted on this edge (slave drives)
//   mem_data  fetched byte (slave drives)
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_re;
  logic                  mem_rdy;
  logic [7:0]            mem_data;

  modport master (
    output mem_addr,
    output mem_re,
    input  mem_rdy,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_re,
    output mem_rdy,
    output mem_data
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer feeding the microcoded decoder
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   bus             memory read bus (fetch_unit_if.master)
//   len_i           operand byte count (0-3) decoded from insn
//   exec_done_i     final microcode step of the instruction
//   br_we_i         load pc from br_addr_i (EXEC only)
//   br_addr_i       branch target
//   insn_o, d1_o..d3_o  registered opcode and operand bytes
//   step_o          microcode step index
//   valid_o         instruction bytes and step valid (EXEC only)
//   pc_o            address of the next byte to fetch
//   step_ovf_o      sticky: an instruction ran out of steps without exec_done
module fetch_unit #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    UCODE_STEPS  = 8,
  localparam int                   SW           = $clog2(UCODE_STEPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_unit_if.master          bus,
  input  logic [1:0]            len_i,
  input  logic                  exec_done_i,
  input  logic                  br_we_i,
  input  logic [ADDR_WIDTH-1:0] br_addr_i,
  output logic [7:0]            insn_o,
  output logic [7:0]            d1_o,
  output logic [7:0]            d2_o,
  output logic [7:0]            d3_o,
  output logic [SW-1:0]         step_o,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  step_ovf_o
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    DECODE    = 2'd1,
    FETCH_OPS = 2'd2,
    EXEC      = 2'd3
  } state_t;

  localparam logic [SW-1:0]         STEP_LAST = SW'(UCODE_STEPS - 1);
  localparam logic [SW-1:0]         STEP_ONE  = SW'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE    = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            insn_q, insn_d;
  logic [7:0]            d1_q, d1_d;
  logic [7:0]            d2_q, d2_d;
  logic [7:0]            d3_q, d3_d;
  logic [SW-1:0]         step_q, step_d;
  logic                  valid_q, valid_d;
  logic                  mem_re_q, mem_re_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            cnt_q, cnt_d;   // operand bytes still to fetch
  logic [1:0]            idx_q, idx_d;   // next operand register: 0=d1, 1=d2, 2=d3

  // A read only completes while a request is actually outstanding.
  logic accept;
  assign accept = mem_re_q & bus.mem_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH_OP;
      pc_q     <= RESET_VECTOR;
      insn_q   <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      d3_q     <= '0;
      step_q   <= '0;
      valid_q  <= 1'b0;
      mem_re_q <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      insn_q   <= insn_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      d3_q     <= d3_d;
      step_q   <= step_d;
      valid_q  <= valid_d;
      mem_re_q <= mem_re_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    insn_d   = insn_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    d3_d     = d3_q;
    step_d   = step_q;
    valid_d  = valid_q;
    mem_re_d = mem_re_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;

    unique case (state_q)
      FETCH_OP: begin
        // Raises the request on the first edge out of reset; otherwise keeps it up.
        mem_re_d = 1'b1;
        if (accept) begin
          insn_d   = bus.mem_data;
          d1_d     = '0;
          d2_d     = '0;
          d3_d     = '0;
          pc_d     = pc_q + PC_ONE;
          mem_re_d = 1'b0;
          state_d  = DECODE;
        end
      end

      DECODE: begin
        cnt_d = len_i;
        idx_d = '0;
        if (len_i == 2'd0) begin
          state_d = EXEC;
          valid_d = 1'b1;
          step_d  = '0;
        end else begin
          state_d  = FETCH_OPS;
          mem_re_d = 1'b1;
        end
      end

      FETCH_OPS: begin
        if (accept) begin
          unique case (idx_q)
            2'd0:    d1_d = bus.mem_data;
            2'd1:    d2_d = bus.mem_data;
            default: d3_d = bus.mem_data;
          endcase
          idx_d = idx_q + 2'd1;
          cnt_d = cnt_q - 2'd1;
          pc_d  = pc_q + PC_ONE;
          if (cnt_q == 2'd1) begin
            state_d  = EXEC;
            mem_re_d = 1'b0;
            valid_d  = 1'b1;
            step_d   = '0;
          end
        end
      end

      EXEC: begin
        if (br_we_i) begin
          pc_d = br_addr_i;
        end
        // Leaving EXEC raises the next opcode request straight away.
        if (exec_done_i || step_q == STEP_LAST) begin
          if (!exec_done_i) begin
            ovf_d = 1'b1;
          end
          state_d  = FETCH_OP;
          step_d   = '0;
          valid_d  = 1'b0;
          mem_re_d = 1'b1;
        end else begin
          step_d = step_q + STEP_ONE;
        end
      end

      default: state_d = FETCH_OP;
    endcase
  end

  assign bus.mem_addr = pc_q;
  assign bus.mem_re   = mem_re_q;
  assign insn_o       = insn_q;
  assign d1_o         = d1_q;
  assign d2_o         = d2_q;
  assign d3_o         = d3_q;
  assign step_o       = step_q;
  assign valid_o      = valid_q;
  assign pc_o         = pc_q;
  assign step_ovf_o   = ovf_q;

endmodule
